// File: rtl/ghost_rand_arbiter_if.sv
// Ghost-side bus of the random-direction arbiter: per-ghost requests and
// legal-direction masks in, one grant strobe with id/direction out.
interface ghost_rand_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] allow_mask;
  logic               busy;
  logic               gnt_valid;
  logic [IDW-1:0]     gnt_id;
  logic [1:0]         gnt_dir;
  logic               gnt_fallback;

  // Ghost controllers drive requests and masks, and watch for their grant.
  modport master (
    output req,
    output allow_mask,
    input  busy,
    input  gnt_valid,
    input  gnt_id,
    input  gnt_dir,
    input  gnt_fallback
  );

  // The arbiter consumes requests and masks, and produces the grant.
  modport slave (
    input  req,
    input  allow_mask,
    output busy,
    output gnt_valid,
    output gnt_id,
    output gnt_dir,
    output gnt_fallback
  );

endinterface

// File: rtl/ghost_rand_arbiter.sv
// Shares one LFSR among the ghost AI blocks. Requesters are served
// round-robin; each service rejection-samples LFSR draws against the
// requester's legal-direction mask and falls back to the lowest legal
// direction after MAX_TRIES rejected draws. The LFSR only steps in DRAW.
module ghost_rand_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 8   // legal range 1..15
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  ghost_rand_arbiter_if.slave  bus,
  input  logic [3:0]           rng_val,
  output logic                 rng_en
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    SAMPLE = 2'd2,
    GRANT  = 2'd3
  } state_t;

  // Registered state and latched service context.
  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_cur_id;
  logic [3:0]     r_cur_mask;
  logic [3:0]     r_tries;
  logic [1:0]     r_dir;
  logic           r_fallback;

  // Next-state values computed by the combinational process.
  state_t         w_state_nxt;
  logic [IDW-1:0] w_rr_ptr_nxt;
  logic [IDW-1:0] w_cur_id_nxt;
  logic [3:0]     w_cur_mask_nxt;
  logic [3:0]     w_tries_nxt;
  logic [1:0]     w_dir_nxt;
  logic           w_fallback_nxt;

  // Round-robin selection results.
  logic           w_found;
  logic [IDW-1:0] w_pick_id;
  logic [3:0]     w_pick_mask;
  logic [1:0]     w_candidate;

  // Only the low two LFSR bits form a direction.
  logic           w_unused_rng_hi;
  assign w_unused_rng_hi = ^rng_val[3:2];
  assign w_candidate     = rng_val[1:0];

  // (base + off) mod N_REQ, for off in 0..N_REQ-1.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDW'(sum);
  endfunction

  // Index of the lowest set bit; used for the deterministic fallback.
  function automatic logic [1:0] lowest_dir(input logic [3:0] mask);
    logic [1:0] dir;
    dir = 2'd0;
    for (int d = 3; d >= 0; d--) begin
      if (mask[d]) dir = 2'(d);
    end
    return dir;
  endfunction

  // First requester at or after the round-robin pointer, searching upward.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    w_found   = 1'b0;
    w_pick_id = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!w_found && bus.req[wrap_add(r_rr_ptr, off)]) begin
        w_found   = 1'b1;
        w_pick_id = wrap_add(r_rr_ptr, off);
      end
    end
  end

  // Legal-direction mask of the selected requester.
  always_comb begin
    w_pick_mask = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_id == IDW'(i)) w_pick_mask = bus.allow_mask[4*i +: 4];
    end
  end

  // Next-state and service-context update.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_cur_id_nxt   = r_cur_id;
    w_cur_mask_nxt = r_cur_mask;
    w_tries_nxt    = r_tries;
    w_dir_nxt      = r_dir;
    w_fallback_nxt = r_fallback;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_cur_id_nxt   = w_pick_id;
          w_cur_mask_nxt = w_pick_mask;
          w_tries_nxt    = 4'd0;
          if (w_pick_mask != 4'd0) begin
            w_state_nxt = DRAW;
          end else begin
            // Nothing legal: grant direction 0 without touching the LFSR.
            w_dir_nxt      = 2'd0;
            w_fallback_nxt = 1'b1;
            w_state_nxt    = GRANT;
          end
        end
      end

      DRAW: begin
        w_tries_nxt = r_tries + 4'd1;
        w_state_nxt = SAMPLE;
      end

      SAMPLE: begin
        if (r_cur_mask[w_candidate]) begin
          w_dir_nxt      = w_candidate;
          w_fallback_nxt = 1'b0;
          w_state_nxt    = GRANT;
        end else if (r_tries == TRIES_LIMIT) begin
          w_dir_nxt      = lowest_dir(r_cur_mask);
          w_fallback_nxt = 1'b1;
          w_state_nxt    = GRANT;
        end else begin
          w_state_nxt = DRAW;
        end
      end

      GRANT: begin
        w_rr_ptr_nxt = wrap_add(r_cur_id, 1);
        w_state_nxt  = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // State and context registers; reset abandons any service in progress.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_cur_id   <= '0;
      r_cur_mask <= 4'd0;
      r_tries    <= 4'd0;
      r_dir      <= 2'd0;
      r_fallback <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_cur_id   <= w_cur_id_nxt;
      r_cur_mask <= w_cur_mask_nxt;
      r_tries    <= w_tries_nxt;
      r_dir      <= w_dir_nxt;
      r_fallback <= w_fallback_nxt;
    end
  end

  // Moore outputs decoded from registered state; grant fields read 0
  // outside GRANT so every output is 0 while idle or in reset.
  assign rng_en           = (r_state == DRAW);
  assign bus.busy         = (r_state != IDLE);
  assign bus.gnt_valid    = (r_state == GRANT);
  assign bus.gnt_id       = (r_state == GRANT) ? r_cur_id   : '0;
  assign bus.gnt_dir      = (r_state == GRANT) ? r_dir      : 2'd0;
  assign bus.gnt_fallback = (r_state == GRANT) ? r_fallback : 1'b0;

endmodule
